// File: rtl/param_array_sorter.sv
// Handshaked block sorter: loads DEPTH words, sorts them in place with a fixed
// DEPTH-pass odd-even transposition network, then streams the sorted frame out.
module param_array_sorter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DEPTH   = 8,
   parameter bit          DESCEND = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int unsigned       IDX_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_SORT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [IDX_W-1:0] r_pass;
   logic [IDX_W-1:0] w_pass_nxt;
   logic             w_accept;
   logic [WIDTH-1:0] r_mem      [DEPTH];
   logic [WIDTH-1:0] w_pass_res [DEPTH];
   logic [DEPTH-2:0] w_swap;

   // Pair (g,g+1) is active on passes whose parity matches g; swap only if strictly out of order.
   for (genvar g = 0; g < DEPTH - 1; g++) begin : g_cmp
      assign w_swap[g] = (r_pass[0] == 1'(g % 2)) &&
                         (DESCEND ? (r_mem[g] < r_mem[g+1]) : (r_mem[g] > r_mem[g+1]));
   end

   // Active pairs are disjoint, so each slot takes at most one neighbour.
   for (genvar k = 0; k < DEPTH; k++) begin : g_net
      if (k == 0) begin : g_first
         assign w_pass_res[k] = w_swap[0] ? r_mem[1] : r_mem[0];
      end else if (k == DEPTH - 1) begin : g_lastw
         assign w_pass_res[k] = w_swap[k-1] ? r_mem[k-1] : r_mem[k];
      end else begin : g_mid
         assign w_pass_res[k] = w_swap[k]   ? r_mem[k+1] :
                                w_swap[k-1] ? r_mem[k-1] : r_mem[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_LOAD;
         r_idx   <= '0;
         r_pass  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_pass  <= w_pass_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_pass_nxt  = r_pass;
      w_accept    = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_LOAD: begin
            in_ready = 1'b1;
            w_accept = in_valid;
            if (in_valid) begin
               if (r_idx == LAST_IDX) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_SORT;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         S_SORT: begin
            busy = 1'b1;
            if (r_pass == LAST_IDX) begin
               w_pass_nxt  = '0;
               w_state_nxt = S_DRAIN;
            end else begin
               w_pass_nxt = r_pass + 1'b1;
            end
         end
         S_DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = (r_idx == LAST_IDX);
            if (out_ready) begin
               if (r_idx == LAST_IDX) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_LOAD;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         default: w_state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem <= '{default: '0};
      end else if (w_accept) begin
         r_mem[r_idx] <= in_data;
      end else if (r_state == S_SORT) begin
         r_mem <= w_pass_res;
      end
   end

   assign out_data = r_mem[r_idx];

endmodule

// File: tb/tb_param_array_sorter.sv
// Directed bench for param_array_sorter: three instances (ascending 8x8,
// descending 8x8, 12-bit x4) share stimulus through a select index.
module tb_param_array_sorter;

   typedef struct {
      string              name;
      int                 sel;
      int                 n;
      bit                 gaps;
      bit                 bp;
      logic [7:0][11:0]   din;
      logic [7:0][11:0]   exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [11:0] in_data;
   int          sel;

   logic        a_ir, a_ov, a_ol, a_busy;
   logic [7:0]  a_od;
   logic        d_ir, d_ov, d_ol, d_busy;
   logic [7:0]  d_od;
   logic        s_ir, s_ov, s_ol, s_busy;
   logic [11:0] s_od;

   logic        o_ir, o_ov, o_ol, o_busy;
   logic [11:0] o_od;

   int n_cmp = 0;
   int n_err = 0;
   vec_t vecs [6];

   always #5 clk = ~clk;

   param_array_sorter #(.WIDTH(8), .DEPTH(8), .DESCEND(1'b0)) u_asc (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(a_ir),
      .in_data(in_data[7:0]), .out_valid(a_ov), .out_ready(out_ready && sel == 0),
      .out_data(a_od), .out_last(a_ol), .busy(a_busy));

   param_array_sorter #(.WIDTH(8), .DEPTH(8), .DESCEND(1'b1)) u_desc (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(d_ir),
      .in_data(in_data[7:0]), .out_valid(d_ov), .out_ready(out_ready && sel == 1),
      .out_data(d_od), .out_last(d_ol), .busy(d_busy));

   param_array_sorter #(.WIDTH(12), .DEPTH(4), .DESCEND(1'b0)) u_w12 (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(s_ir),
      .in_data(in_data), .out_valid(s_ov), .out_ready(out_ready && sel == 2),
      .out_data(s_od), .out_last(s_ol), .busy(s_busy));

   always_comb begin
      case (sel)
         1:       begin o_ir = d_ir; o_ov = d_ov; o_ol = d_ol; o_busy = d_busy; o_od = {4'h0, d_od}; end
         2:       begin o_ir = s_ir; o_ov = s_ov; o_ol = s_ol; o_busy = s_busy; o_od = s_od; end
         default: begin o_ir = a_ir; o_ov = a_ov; o_ol = a_ol; o_busy = a_busy; o_od = {4'h0, a_od}; end
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0][11:0] pk(input logic [11:0] a0, a1, a2, a3, a4, a5, a6, a7);
      logic [7:0][11:0] r;
      r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
      r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
      return r;
   endfunction

   // Returns just after the edge that accepts the final word.
   task automatic load_frame(input vec_t v);
      for (int i = 0; i < v.n; i++) begin
         @(negedge clk);
         if (v.gaps && (i % 2 == 1)) begin
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
         end
         chk({v.name, "/in_ready_load"}, 32'(o_ir), 32'd1);
         in_valid = 1'b1;
         in_data  = v.din[i];
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain_frame(input vec_t v);
      int          j;
      int          k;
      int          cyc;
      int          busy_cnt;
      bit          stall;
      logic [11:0] pd;
      logic        pl;
      j = 0; busy_cnt = 0;
      while (j < 64) begin
         @(negedge clk);
         if (o_ov) break;
         busy_cnt += int'(o_busy);
         chk({v.name, "/in_ready_sort"}, 32'(o_ir), 32'd0);
         j++;
      end
      chk({v.name, "/latency"}, 32'(j), 32'(v.n));
      k = 0; cyc = 0; stall = 1'b0; pd = '0; pl = 1'b0;
      while (k < v.n && cyc < 200) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         busy_cnt += int'(o_busy);
         chk({v.name, "/out_valid_drain"}, 32'(o_ov), 32'd1);
         if (stall) begin
            chk({v.name, "/hold_data"}, 32'(o_od), 32'(pd));
            chk({v.name, "/hold_last"}, 32'(o_ol), 32'(pl));
         end
         out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_ov && out_ready) begin
            chk({v.name, $sformatf("/data[%0d]", k)}, 32'(o_od), 32'(v.exp[k]));
            chk({v.name, $sformatf("/last[%0d]", k)}, 32'(o_ol), 32'(k == v.n - 1));
            k++;
            stall = 1'b0;
         end else begin
            stall = 1'b1;
            pd    = o_od;
            pl    = o_ol;
         end
      end
      if (k < v.n) chk({v.name, "/drain_timeout"}, 32'(k), 32'(v.n));
      @(negedge clk);
      out_ready = 1'b0;
      chk({v.name, "/in_ready_after"}, 32'(o_ir), 32'd1);
      chk({v.name, "/out_valid_after"}, 32'(o_ov), 32'd0);
      chk({v.name, "/busy_after"}, 32'(o_busy), 32'd0);
      if (!v.bp) chk({v.name, "/busy_cycles"}, 32'(busy_cnt), 32'(2 * v.n));
   endtask

   initial begin
      vecs[0] = '{"basic", 0, 8, 1'b0, 1'b0,
                  pk(12'h05, 12'h03, 12'h07, 12'h01, 12'h08, 12'h02, 12'h06, 12'h04),
                  pk(12'h01, 12'h02, 12'h03, 12'h04, 12'h05, 12'h06, 12'h07, 12'h08)};
      vecs[1] = '{"descend", 1, 8, 1'b0, 1'b0,
                  pk(12'h10, 12'h40, 12'h20, 12'h30, 12'h80, 12'h50, 12'h70, 12'h60),
                  pk(12'h80, 12'h70, 12'h60, 12'h50, 12'h40, 12'h30, 12'h20, 12'h10)};
      vecs[2] = '{"dups", 0, 8, 1'b0, 1'b0,
                  pk(12'h07, 12'h07, 12'h00, 12'hFF, 12'h00, 12'h07, 12'hFF, 12'h00),
                  pk(12'h00, 12'h00, 12'h00, 12'h07, 12'h07, 12'h07, 12'hFF, 12'hFF)};
      vecs[3] = '{"backpressure", 0, 8, 1'b0, 1'b1,
                  pk(12'h20, 12'h1F, 12'hC3, 12'h00, 12'h7F, 12'h80, 12'h01, 12'hFE),
                  pk(12'h00, 12'h01, 12'h1F, 12'h20, 12'h7F, 12'h80, 12'hC3, 12'hFE)};
      vecs[4] = '{"reverse", 0, 8, 1'b0, 1'b0,
                  pk(12'h08, 12'h07, 12'h06, 12'h05, 12'h04, 12'h03, 12'h02, 12'h01),
                  pk(12'h01, 12'h02, 12'h03, 12'h04, 12'h05, 12'h06, 12'h07, 12'h08)};
      vecs[5] = '{"w12d4", 2, 4, 1'b1, 1'b0,
                  pk(12'h001, 12'h002, 12'hFFF, 12'h800, 12'h0, 12'h0, 12'h0, 12'h0),
                  pk(12'h001, 12'h002, 12'h800, 12'hFFF, 12'h0, 12'h0, 12'h0, 12'h0)};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; sel = 0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk($sformatf("reset%0d/in_ready", s), 32'(o_ir), 32'd1);
         chk($sformatf("reset%0d/out_valid", s), 32'(o_ov), 32'd0);
         chk($sformatf("reset%0d/out_data", s), 32'(o_od), 32'd0);
         chk($sformatf("reset%0d/out_last", s), 32'(o_ol), 32'd0);
         chk($sformatf("reset%0d/busy", s), 32'(o_busy), 32'd0);
      end
      sel = 0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         sel = vecs[i].sel;
         load_frame(vecs[i]);
         drain_frame(vecs[i]);
      end

      // Reset three cycles into SORT, then a fresh frame must sort cleanly.
      sel = 0;
      load_frame(vecs[0]);
      repeat (3) @(negedge clk);
      chk("midreset/busy_before", 32'(o_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("midreset/in_ready", 32'(o_ir), 32'd1);
      chk("midreset/out_valid", 32'(o_ov), 32'd0);
      chk("midreset/busy", 32'(o_busy), 32'd0);
      chk("midreset/out_data", 32'(o_od), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      load_frame(vecs[4]);
      drain_frame(vecs[4]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
